poly_tone_gen: RTL and testbench

Parametrised multi-voice successor to the single-voice square-wave buzzer. It runs NUM_VOICES independent square-wave oscillators, each with its own note divider, amplitude and pan. Voices are mixed with saturation into signed 16-bit left/right samples that feed the existing I2S speaker serializer directly. Note changes are glitch-free: a new divider takes effect only at a half-period boundary.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/poly_tone_gen_pkg.sv | 11 +
 rtl/poly_tone_gen_if.sv | 27 ++
 rtl/tone_voice.sv | 120 ++++++++++++
 rtl/poly_tone_gen.sv | 90 +++++++++
 tb/tb_poly_tone_gen.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/audio_pkg.sv
// Shared audio sample types, pan encoding and saturation helpers.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ACC_W    = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]    acc_t;
    typedef logic [1:0]                 pan_t;

    localparam sample_t SAMPLE_MAX = 16'sh7FFF;
    localparam sample_t SAMPLE_MIN = 16'sh8000;

    // 2'b11 also routes to both channels
    localparam pan_t PAN_BOTH  = 2'b00;
    localparam pan_t PAN_LEFT  = 2'b01;
    localparam pan_t PAN_RIGHT = 2'b10;

    // Clamp a wide signed sum into the sample range.
    function automatic sample_t sat_clip(input acc_t x);
        if (x > acc_t'(SAMPLE_MAX)) return SAMPLE_MAX;
        if (x < acc_t'(SAMPLE_MIN)) return SAMPLE_MIN;
        return sample_t'(x);
    endfunction

    // Saturating add of two samples.
    function automatic sample_t sat_add(input sample_t a, input sample_t b);
        return sat_clip(acc_t'(a) + acc_t'(b));
    endfunction

endpackage

// File: rtl/poly_tone_gen_pkg.sv
// Payload types for the poly_tone_gen voice-to-mixer path.
package poly_tone_gen_pkg;
    import audio_pkg::*;

    // Stage-1 voice output: signed contribution plus its pan routing.
    typedef struct packed {
        pan_t    pan;
        sample_t contrib;
    } voice_out_t;

endpackage

// File: rtl/poly_tone_gen_if.sv
// Control/sample bus of poly_tone_gen; master drives notes, slave is the generator.
interface poly_tone_gen_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned DIV_W      = 23,
    parameter int unsigned AMP_W      = 13
);
    import audio_pkg::*;

    logic [NUM_VOICES-1:0]       voice_en;
    logic [NUM_VOICES*DIV_W-1:0] note_div;
    logic [NUM_VOICES-1:0]       note_vld;
    logic [NUM_VOICES*AMP_W-1:0] amp;
    logic [NUM_VOICES*2-1:0]     pan;
    sample_t                     audio_left;
    sample_t                     audio_right;

    modport master (
        output voice_en, note_div, note_vld, amp, pan,
        input  audio_left, audio_right
    );

    modport slave (
        input  voice_en, note_div, note_vld, amp, pan,
        output audio_left, audio_right
    );

endinterface

// File: rtl/tone_voice.sv
// One square-wave oscillator with glitch-free divider updates and a
// registered signed contribution. Optional envelope under POLY_TONE_ENV_RAMP_EN.
module tone_voice
    import audio_pkg::*;
    import poly_tone_gen_pkg::*;
#(
    parameter int unsigned DIV_W = 23,
    parameter int unsigned AMP_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             voice_en,
    input  logic [DIV_W-1:0] note_div,
    input  logic             note_vld,
    input  logic [AMP_W-1:0] amp,
    input  pan_t             pan,
`ifdef POLY_TONE_ENV_RAMP_EN
    input  logic             env_tick,
`endif
    output voice_out_t       vout
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_active;
    logic [DIV_W-1:0] div_pending;
    logic             phase;
    logic             pend_flag;

    logic             run_c;
    logic             wrap_c;
    logic [AMP_W-1:0] level_c;
    sample_t          mag_c;

`ifdef POLY_TONE_ENV_RAMP_EN
    logic [AMP_W-1:0] env;
    logic             active_c;
    logic [AMP_W-1:0] target_c;

    // Oscillator keeps running after disable until the envelope has drained.
    assign active_c = voice_en && (div_active != '0);
    assign run_c    = (div_active != '0) && (voice_en || (env != '0));
    assign target_c = active_c ? amp : '0;
    assign level_c  = env;

    // Envelope steps one LSB toward its target on each prescaler tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            env <= '0;
        end else if (env_tick) begin
            if (env < target_c) begin
                env <= env + AMP_W'(1);
            end else if (env > target_c) begin
                env <= env - AMP_W'(1);
            end
        end
    end
`else
    assign run_c   = voice_en && (div_active != '0);
    assign level_c = amp;
`endif

    assign wrap_c = run_c && (cnt == (div_active - DIV_W'(1)));
    assign mag_c  = SAMPLE_W'(level_c);

    // Half-period counter, phase and divider hand-over at the wrap boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            phase       <= 1'b0;
            div_active  <= '0;
            div_pending <= '0;
            pend_flag   <= 1'b0;
        end else if (!run_c) begin
            // Idle voice: hold at start of period and adopt any pending note now.
            cnt       <= '0;
            phase     <= 1'b0;
            pend_flag <= note_vld;
            if (pend_flag) begin
                div_active <= div_pending;
            end
            if (note_vld) begin
                div_pending <= note_div;
            end
        end else if (wrap_c) begin
            cnt   <= '0;
            phase <= ~phase;
            // A note arriving exactly at the wrap wins over the older pending one.
            if (note_vld) begin
                div_active <= note_div;
                pend_flag  <= 1'b0;
            end else if (pend_flag) begin
                div_active <= div_pending;
                pend_flag  <= 1'b0;
            end
        end else begin
            cnt <= cnt + DIV_W'(1);
            if (note_vld) begin
                div_pending <= note_div;
                pend_flag   <= 1'b1;
            end
        end
    end

    // Stage 1: signed contribution from current phase, zero when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vout <= '0;
        end else begin
            vout.pan <= pan;
            if (!run_c) begin
                vout.contrib <= '0;
            end else if (phase) begin
                vout.contrib <= mag_c;
            end else begin
                vout.contrib <= -mag_c;
            end
        end
    end

endmodule

// File: rtl/poly_tone_gen.sv
// Multi-voice square-wave generator with saturating stereo mixer.
// Optional envelope ramp enabled by defining POLY_TONE_ENV_RAMP_EN.
module poly_tone_gen
    import audio_pkg::*;
    import poly_tone_gen_pkg::*;
#(
    parameter int unsigned NUM_VOICES    = 4,
    parameter int unsigned DIV_W         = 23,
    parameter int unsigned AMP_W         = 13
`ifdef POLY_TONE_ENV_RAMP_EN
    ,
    parameter int unsigned RAMP_STEP_CYC = 1024
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    poly_tone_gen_if.slave bus
);

    localparam int unsigned SUM_W = SAMPLE_W + $clog2(NUM_VOICES);

    voice_out_t             vout [NUM_VOICES];
    logic signed [SUM_W-1:0] sum_l_c;
    logic signed [SUM_W-1:0] sum_r_c;

`ifdef POLY_TONE_ENV_RAMP_EN
    localparam int unsigned PRE_W = (RAMP_STEP_CYC > 1) ? $clog2(RAMP_STEP_CYC) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             env_tick;

    assign env_tick = (pre_cnt == PRE_W'(RAMP_STEP_CYC - 1));

    // Shared envelope prescaler, one tick every RAMP_STEP_CYC cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (env_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end
`endif

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        tone_voice #(
            .DIV_W (DIV_W),
            .AMP_W (AMP_W)
        ) u_voice (
            .clk      (clk),
            .rst_n    (rst_n),
            .voice_en (bus.voice_en[gi]),
            .note_div (bus.note_div[gi*DIV_W +: DIV_W]),
            .note_vld (bus.note_vld[gi]),
            .amp      (bus.amp[gi*AMP_W +: AMP_W]),
            .pan      (bus.pan[gi*2 +: 2]),
`ifdef POLY_TONE_ENV_RAMP_EN
            .env_tick (env_tick),
`endif
            .vout     (vout[gi])
        );
    end

    // Per-channel wide sum of pan-routed contributions.
    always_comb begin
        sum_l_c = '0;
        sum_r_c = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (vout[i].pan != PAN_RIGHT) begin
                sum_l_c = sum_l_c + SUM_W'(signed'(vout[i].contrib));
            end
            if (vout[i].pan != PAN_LEFT) begin
                sum_r_c = sum_r_c + SUM_W'(signed'(vout[i].contrib));
            end
        end
    end

    // Stage 2: saturate the mix into 16-bit samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.audio_left  <= '0;
            bus.audio_right <= '0;
        end else begin
            bus.audio_left  <= sat_clip(acc_t'(sum_l_c));
            bus.audio_right <= sat_clip(acc_t'(sum_r_c));
        end
    end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Self-checking bench for poly_tone_gen (default build and POLY_TONE_ENV_RAMP_EN build).
module tb_poly_tone_gen;
    import audio_pkg::*;

    localparam int NV = 4;
    localparam int DW = 10;
    localparam int AW = 15;
`ifdef POLY_TONE_ENV_RAMP_EN
    localparam int STEP = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    poly_tone_gen_if #(.NUM_VOICES(NV), .DIV_W(DW), .AMP_W(AW)) bus ();

    poly_tone_gen #(
        .NUM_VOICES (NV),
        .DIV_W      (DW),
        .AMP_W      (AW)
`ifdef POLY_TONE_ENV_RAMP_EN
        ,
        .RAMP_STEP_CYC (STEP)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stimulus variables, one entry per voice
    bit en   [NV];
    bit vld  [NV];
    int ndiv [NV];
    int ampv [NV];
    int panv [NV];

    // Reference model state
    int m_cnt [NV];
    int m_ph  [NV];
    int m_div [NV];
    int m_pend[NV];
    int m_pf  [NV];
    int m_cl  [NV];
    int m_cr  [NV];
    int m_left;
    int m_right;
`ifdef POLY_TONE_ENV_RAMP_EN
    int m_env [NV];
    int m_pre;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int clip16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // One clock of the behavioural model, using the inputs present at the edge.
    function automatic void model_step();
        int sum_l;
        int sum_r;
`ifdef POLY_TONE_ENV_RAMP_EN
        bit tick;
`endif
        if (rst_n == 1'b0) begin
            for (int i = 0; i < NV; i++) begin
                m_cnt[i] = 0; m_ph[i] = 0; m_div[i] = 0; m_pend[i] = 0; m_pf[i] = 0;
                m_cl[i] = 0; m_cr[i] = 0;
`ifdef POLY_TONE_ENV_RAMP_EN
                m_env[i] = 0;
`endif
            end
`ifdef POLY_TONE_ENV_RAMP_EN
            m_pre = 0;
`endif
            m_left = 0;
            m_right = 0;
            return;
        end
        sum_l = 0;
        sum_r = 0;
        for (int i = 0; i < NV; i++) begin
            sum_l += m_cl[i];
            sum_r += m_cr[i];
        end
        m_left  = clip16(sum_l);
        m_right = clip16(sum_r);
`ifdef POLY_TONE_ENV_RAMP_EN
        tick  = (m_pre == STEP - 1);
        m_pre = tick ? 0 : m_pre + 1;
`endif
        for (int i = 0; i < NV; i++) begin
            bit play;
            int lvl;
            int v;
`ifdef POLY_TONE_ENV_RAMP_EN
            int tgt;
            play = (m_div[i] != 0) && (en[i] || (m_env[i] != 0));
            lvl  = m_env[i];
`else
            play = en[i] && (m_div[i] != 0);
            lvl  = ampv[i];
`endif
            v = play ? ((m_ph[i] != 0) ? lvl : -lvl) : 0;
            m_cl[i] = (panv[i] == 2) ? 0 : v;
            m_cr[i] = (panv[i] == 1) ? 0 : v;
`ifdef POLY_TONE_ENV_RAMP_EN
            if (tick) begin
                tgt = (en[i] && (m_div[i] != 0)) ? ampv[i] : 0;
                if (m_env[i] < tgt) m_env[i]++;
                else if (m_env[i] > tgt) m_env[i]--;
            end
`endif
            if (!play) begin
                if (m_pf[i] != 0) m_div[i] = m_pend[i];
                m_pf[i] = vld[i] ? 1 : 0;
                if (vld[i]) m_pend[i] = ndiv[i];
                m_cnt[i] = 0;
                m_ph[i] = 0;
            end else if (m_cnt[i] == m_div[i] - 1) begin
                m_cnt[i] = 0;
                m_ph[i] = 1 - m_ph[i];
                if (vld[i]) begin
                    m_div[i] = ndiv[i];
                    m_pf[i] = 0;
                end else if (m_pf[i] != 0) begin
                    m_div[i] = m_pend[i];
                    m_pf[i] = 0;
                end
            end else begin
                m_cnt[i]++;
                if (vld[i]) begin
                    m_pend[i] = ndiv[i];
                    m_pf[i] = 1;
                end
            end
        end
    endfunction

    task automatic apply();
        for (int i = 0; i < NV; i++) begin
            bus.voice_en[i]            = en[i];
            bus.note_vld[i]            = vld[i];
            bus.note_div[i*DW +: DW]   = DW'(ndiv[i]);
            bus.amp[i*AW +: AW]        = AW'(ampv[i]);
            bus.pan[i*2 +: 2]          = 2'(panv[i]);
        end
    endtask

    // Drive current inputs, take one edge, advance model, settle.
    task automatic cycle();
        apply();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NV; i++) begin
            en[i] = 1'b0; vld[i] = 1'b0; ndiv[i] = 0; ampv[i] = 0; panv[i] = 0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sample_t zero;
        zero = '0;
        rst_n = 1'b0;
        for (int i = 0; i < NV; i++) begin
            en[i] = 1'b1; vld[i] = 1'b1; ndiv[i] = 1 + i;
            ampv[i] = 20000; panv[i] = i % 4;
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (bus.audio_left !== zero)
                $display("FAIL reset_left k=%0d got %0d expected 0", k, bus.audio_left);
            else n_pass++;
            n_checks++;
            if (bus.audio_right !== zero)
                $display("FAIL reset_right k=%0d got %0d expected 0", k, bus.audio_right);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_tone();
        sample_t exp_v;
        do_reset();
        en[0] = 1'b1; ampv[0] = 1000; panv[0] = 0; ndiv[0] = 4; vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if (bus.audio_left !== 16'sd0)
            $display("FAIL basic_pre got %0d expected 0", bus.audio_left);
        else n_pass++;
        for (int k = 0; k < 24; k++) begin
            cycle();
            exp_v = (((k / 4) % 2) == 0) ? -16'sd1000 : 16'sd1000;
            n_checks++;
            if (bus.audio_left !== exp_v)
                $display("FAIL basic_left k=%0d got %0d expected %0d", k, bus.audio_left, exp_v);
            else n_pass++;
            n_checks++;
            if (bus.audio_right !== exp_v)
                $display("FAIL basic_right k=%0d got %0d expected %0d", k, bus.audio_right, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_note_change();
        sample_t exp_v;
        int s;
        do_reset();
        en[0] = 1'b1; ampv[0] = 1000; ndiv[0] = 10; vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        cycle();
        cycle();
        cycle();
        ndiv[0] = 3; vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        for (int t = 5; t <= 40; t++) begin
            cycle();
            s = t - 2;
            if (s <= 10) exp_v = -16'sd1000;
            else exp_v = ((((s - 11) / 3) % 2) == 0) ? 16'sd1000 : -16'sd1000;
            n_checks++;
            if (bus.audio_left !== exp_v)
                $display("FAIL note_change t=%0d got %0d expected %0d", t, bus.audio_left, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        sample_t exp_v;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < NV; i++) begin
                en[i] = 1'b1; ampv[i] = (pass == 0) ? 8191 : 10000;
                panv[i] = 0; ndiv[i] = 4; vld[i] = 1'b1;
            end
            cycle();
            for (int i = 0; i < NV; i++) vld[i] = 1'b0;
            cycle();
            cycle();
            for (int k = 0; k < 8; k++) begin
                cycle();
                if (pass == 0) exp_v = (k < 4) ? -16'sd32764 : 16'sd32764;
                else exp_v = (k < 4) ? SAMPLE_MIN : SAMPLE_MAX;
                n_checks++;
                if (bus.audio_left !== exp_v)
                    $display("FAIL sat_left p=%0d k=%0d got %0d expected %0d", pass, k, bus.audio_left, exp_v);
                else n_pass++;
                n_checks++;
                if (bus.audio_right !== exp_v)
                    $display("FAIL sat_right p=%0d k=%0d got %0d expected %0d", pass, k, bus.audio_right, exp_v);
                else n_pass++;
            end
        end
    endtask

    task automatic test_pan();
        sample_t exp_l;
        sample_t exp_r;
        do_reset();
        en[1] = 1'b1; ampv[1] = 500; panv[1] = 1; ndiv[1] = 4; vld[1] = 1'b1;
        en[2] = 1'b1; ampv[2] = 300; panv[2] = 2; ndiv[2] = 4; vld[2] = 1'b1;
        cycle();
        vld[1] = 1'b0; vld[2] = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 16; k++) begin
            cycle();
            exp_l = (((k / 4) % 2) == 0) ? -16'sd500 : 16'sd500;
            exp_r = (((k / 4) % 2) == 0) ? -16'sd300 : 16'sd300;
            n_checks++;
            if (bus.audio_left !== exp_l)
                $display("FAIL pan_left k=%0d got %0d expected %0d", k, bus.audio_left, exp_l);
            else n_pass++;
            n_checks++;
            if (bus.audio_right !== exp_r)
                $display("FAIL pan_right k=%0d got %0d expected %0d", k, bus.audio_right, exp_r);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        sample_t exp_v;
        do_reset();
        en[0] = 1'b1; ampv[0] = 1000; ndiv[0] = 4; vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        for (int k = 0; k < 13; k++) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_checks++;
        if (bus.audio_left !== 16'sd0 || bus.audio_right !== 16'sd0)
            $display("FAIL mid_reset_out got %0d/%0d expected 0/0", bus.audio_left, bus.audio_right);
        else n_pass++;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_checks++;
            if (bus.audio_left !== 16'sd0 || bus.audio_right !== 16'sd0)
                $display("FAIL mid_reset_silent k=%0d got %0d/%0d expected 0/0", k, bus.audio_left, bus.audio_right);
            else n_pass++;
        end
        vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        cycle();
        cycle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            exp_v = (k < 4) ? -16'sd1000 : 16'sd1000;
            n_checks++;
            if (bus.audio_left !== exp_v)
                $display("FAIL mid_reset_resume k=%0d got %0d expected %0d", k, bus.audio_left, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        sample_t exp_l;
        sample_t exp_r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NV; i++) begin
                if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
                vld[i] = ($urandom_range(0, 7) == 0);
                ndiv[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
                if ($urandom_range(0, 7) == 0) ampv[i] = int'($urandom_range(0, 32767));
                if ($urandom_range(0, 31) == 0) panv[i] = int'($urandom_range(0, 3));
            end
            cycle();
            exp_l = sample_t'(m_left);
            exp_r = sample_t'(m_right);
            n_checks++;
            if (bus.audio_left !== exp_l)
                $display("FAIL rand_left c=%0d got %0d expected %0d", c, bus.audio_left, exp_l);
            else n_pass++;
            n_checks++;
            if (bus.audio_right !== exp_r)
                $display("FAIL rand_right c=%0d got %0d expected %0d", c, bus.audio_right, exp_r);
            else n_pass++;
        end
        rst_n = 1'b1;
    endtask

`ifdef POLY_TONE_ENV_RAMP_EN
    task automatic test_env_ramp();
        sample_t exp_l;
        int n_pos;
        int n_neg;
        do_reset();
        en[0] = 1'b1; ampv[0] = 3; ndiv[0] = 2; vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            exp_l = sample_t'(m_left);
            n_checks++;
            if (bus.audio_left !== exp_l)
                $display("FAIL env_rise k=%0d got %0d expected %0d", k, bus.audio_left, exp_l);
            else n_pass++;
        end
        n_checks++;
        if (bus.audio_left !== 16'sd3 && bus.audio_left !== -16'sd3)
            $display("FAIL env_full got %0d expected +-3", bus.audio_left);
        else n_pass++;
        en[0] = 1'b0;
        n_pos = 0;
        n_neg = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (k < 10 && bus.audio_left > 16'sd0) n_pos++;
            if (k < 10 && bus.audio_left < 16'sd0) n_neg++;
            exp_l = sample_t'(m_left);
            n_checks++;
            if (bus.audio_left !== exp_l)
                $display("FAIL env_decay k=%0d got %0d expected %0d", k, bus.audio_left, exp_l);
            else n_pass++;
        end
        n_checks++;
        if (n_pos == 0 || n_neg == 0)
            $display("FAIL env_toggle got pos=%0d neg=%0d expected both nonzero", n_pos, n_neg);
        else n_pass++;
        n_checks++;
        if (bus.audio_left !== 16'sd0 || bus.audio_right !== 16'sd0)
            $display("FAIL env_silent got %0d/%0d expected 0/0", bus.audio_left, bus.audio_right);
        else n_pass++;
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
`ifndef POLY_TONE_ENV_RAMP_EN
        test_basic_tone();
        test_note_change();
        test_saturation();
        test_pan();
        test_mid_reset();
`else
        test_env_ramp();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
